// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI mode-0 slave.
// Holds the default transfer word length.
package spi_slave_pkg;

    localparam int SPI_DW = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Ports: clk, rst (async active-low), i_d (async in), o_q (synced out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk.
// Ports: clk, rst, ss, sck, mosi in; miso, done, dout out; din in.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic w_sck_s;
    logic w_ss_s;
    logic w_mosi_s;
    logic w_rise;
    logic w_fall;
    logic [DATA_WIDTH-1:0] w_next;

    logic                  r_sck_prev;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_miso;
    logic                  r_done;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sck (
        .clk (clk),
        .rst (rst),
        .i_d (sck),
        .o_q (w_sck_s)
    );

    // Deselected after reset, so ss syncs to 1.
    sync_2ff #(.RST_VAL(1'b1)) u_sync_ss (
        .clk (clk),
        .rst (rst),
        .i_d (ss),
        .o_q (w_ss_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .i_d (mosi),
        .o_q (w_mosi_s)
    );

    assign w_rise = w_sck_s & ~r_sck_prev;
    assign w_fall = ~w_sck_s & r_sck_prev;
    assign w_next = {r_shift[DATA_WIDTH-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_prev <= 1'b0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_miso     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sck_prev <= w_sck_s;
            r_done     <= 1'b0;
            if (w_ss_s) begin
                r_cnt   <= '0;
                r_shift <= din;
                r_miso  <= din[DATA_WIDTH-1];
            end else if (w_rise) begin
                if (r_cnt == LAST) begin
                    // Last bit: publish and reload for next byte.
                    r_dout  <= w_next;
                    r_done  <= 1'b1;
                    r_shift <= din;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= w_next;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else if (w_fall) begin
                // Present next bit for master's next rise.
                r_miso <= r_shift[DATA_WIDTH-1];
            end
        end
    end

    assign miso = r_miso;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized self-checking bench for spi_slave.
// Acts as a mode-0 SPI master and checks against a byte-level model.
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic       ss;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       done;
    logic [7:0] din;
    logic [7:0] dout;

    int errors;
    int checks;
    int done_cnt;

    spi_slave #(.DATA_WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .ss   (ss),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso),
        .done (done),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, one per high cycle.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits, MSB first from mo; returns sampled miso bits
    // in mi[7 -: n] and the posedge index where done appeared.
    task automatic xfer(
        input  int         n,
        input  logic [7:0] mo,
        output logic [7:0] mi,
        output int         lat
    );
        mi  = '0;
        lat = 0;
        for (int i = 0; i < n; i++) begin
            mosi = mo[7-i];
            wait_neg(10);
            mi[7-i] = miso;
            sck = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1 && lat == 0) lat = k;
            end
            @(negedge clk);
            sck = 1'b0;
        end
    endtask

    logic [7:0] mi;
    logic [7:0] mi2;
    logic [7:0] mo;
    logic [7:0] nd;
    logic [7:0] exp_dout;
    int         lat;
    int         base;

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        rst  = 1'b0;
        ss   = 1'($urandom);
        sck  = 1'($urandom);
        mosi = 1'($urandom);
        din  = 8'($urandom);
        wait_neg(4);
        check("rst_miso", 32'(miso), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dout", 32'(dout), 0);

        sck  = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        din  = 8'hAA;
        rst  = 1'b1;
        wait_neg(6);
        check("idle_miso", 32'(miso), 1);

        // Byte 1 and back-to-back byte 2.
        ss = 1'b0;
        base = done_cnt;
        xfer(8, 8'hFF, mi, lat);
        wait_neg(12);
        check("b1_miso", 32'(mi), 32'h AA);
        check("b1_dout", 32'(dout), 32'hFF);
        check("b1_done", 32'(done_cnt - base), 1);
        check("b1_lat", 32'(lat), 3);
        base = done_cnt;
        xfer(8, 8'h00, mi, lat);
        wait_neg(12);
        check("b2_miso", 32'(mi), 32'hAA);
        check("b2_dout", 32'(dout), 32'h00);
        check("b2_done", 32'(done_cnt - base), 1);
        check("b2_lat", 32'(lat), 3);
        exp_dout = 8'h00;

        // Abort after 5 bits.
        ss = 1'b1;
        din = 8'($urandom);
        wait_neg(10);
        ss = 1'b0;
        base = done_cnt;
        xfer(5, 8'($urandom), mi, lat);
        ss = 1'b1;
        wait_neg(12);
        check("ab_done", 32'(done_cnt - base), 0);
        check("ab_dout", 32'(dout), 32'(exp_dout));
        ss = 1'b0;
        xfer(8, 8'h3C, mi, lat);
        wait_neg(12);
        check("ab_miso", 32'(mi), 32'(din));
        check("ab_byte", 32'(dout), 32'h3C);
        check("ab_cnt", 32'(done_cnt - base), 1);

        // din set while deselected, then changed mid-byte.
        ss = 1'b1;
        din = 8'h55;
        wait_neg(10);
        ss = 1'b0;
        mo = 8'($urandom);
        nd = 8'($urandom);
        xfer(4, mo, mi, lat);
        din = nd;
        xfer(4, mo << 4, mi2, lat);
        wait_neg(12);
        check("dc_miso", 32'({mi[7:4], mi2[7:4]}), 32'h55);
        check("dc_dout", 32'(dout), 32'(mo));
        mo = 8'($urandom);
        xfer(8, mo, mi, lat);
        wait_neg(12);
        check("dc_next", 32'(mi), 32'(nd));
        check("dc_dout2", 32'(dout), 32'(mo));

        // Random bytes with fresh din per byte.
        for (int j = 0; j < 6; j++) begin
            ss = 1'b1;
            din = 8'($urandom);
            wait_neg(10);
            ss = 1'b0;
            mo = 8'($urandom);
            base = done_cnt;
            xfer(8, mo, mi, lat);
            wait_neg(12);
            check("rnd_miso", 32'(mi), 32'(din));
            check("rnd_dout", 32'(dout), 32'(mo));
            check("rnd_done", 32'(done_cnt - base), 1);
        end

        // Async reset in the middle of a byte.
        ss = 1'b1;
        din = 8'($urandom);
        wait_neg(10);
        ss = 1'b0;
        xfer(4, 8'($urandom), mi, lat);
        rst = 1'b0;
        #1;
        check("ar_miso", 32'(miso), 0);
        check("ar_done", 32'(done), 0);
        check("ar_dout", 32'(dout), 0);
        wait_neg(3);
        ss = 1'b1;
        rst = 1'b1;
        din = 8'($urandom);
        wait_neg(10);
        ss = 1'b0;
        base = done_cnt;
        xfer(8, 8'h81, mi, lat);
        wait_neg(12);
        check("ar_miso2", 32'(mi), 32'(din));
        check("ar_byte", 32'(dout), 32'h81);
        check("ar_cnt", 32'(done_cnt - base), 1);
        ss = 1'b1;
        wait_neg(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
